// File: rtl/branch_pht.sv
// rtl/branch_pht.sv - pattern history table of saturating counters with optional gshare indexing
module branch_pht #(
  parameter int W_PC    = 32,
  parameter int N_IDX   = 6,
  parameter int W_CTR   = 2,
  parameter int USE_GHR = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             lk_v_i,
  input  logic [W_PC-1:0]  lk_pc_i,
  output logic             pred_v_o,
  output logic             pred_o,
  output logic [N_IDX-1:0] pred_idx_o,
  input  logic             upd_v_i,
  input  logic [N_IDX-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  output logic             ready_o
);

  localparam int DEPTH = 1 << N_IDX;
  // Weakly not-taken: the largest value whose MSB is still clear.
  localparam logic [W_CTR-1:0] INITV   = W_CTR'((1 << (W_CTR - 1)) - 1);
  localparam logic [W_CTR-1:0] CTR_MAX = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state, state_n;
  logic [N_IDX-1:0] ptr, ptr_n;
  logic [N_IDX-1:0] ghr;
  logic [W_CTR-1:0] tbl [DEPTH];
  logic             run, init_wr, lk_fire, upd_fire, fwd_hit;
  logic [N_IDX-1:0] lk_idx;
  logic [W_CTR-1:0] upd_cur, upd_new;
  logic [N_IDX:0]   ghr_shift;
  logic             unused_pc;

  assign run       = (state == S_RUN);
  assign ready_o   = run;
  // clr_i wins over a same-cycle lookup or update.
  assign lk_fire   = run && !clr_i && lk_v_i;
  assign upd_fire  = run && !clr_i && upd_v_i;
  assign lk_idx    = lk_pc_i[N_IDX+1:2] ^ ((USE_GHR != 0) ? ghr : '0);
  assign upd_cur   = tbl[upd_idx_i];
  assign fwd_hit   = upd_fire && (upd_idx_i == lk_idx);
  // One bit wider than ghr so the shift also works for N_IDX == 1.
  assign ghr_shift = {ghr, upd_taken_i};
  assign unused_pc = ^{lk_pc_i[W_PC-1:N_IDX+2], lk_pc_i[1:0]};

  // Sweep/run sequencing: INIT walks every entry once, clr_i in RUN restarts the sweep.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    init_wr = 1'b0;
    case (state)
      S_INIT: begin
        init_wr = 1'b1;
        ptr_n   = ptr + N_IDX'(1);
        if (ptr == '1) state_n = S_RUN;
      end
      S_RUN: begin
        if (clr_i) begin
          state_n = S_INIT;
          ptr_n   = '0;
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  // State and sweep pointer registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_INIT;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  // Saturating step of the counter being resolved.
  always_comb begin
    upd_new = upd_cur;
    if (upd_taken_i && (upd_cur != CTR_MAX)) upd_new = upd_cur + W_CTR'(1);
    else if (!upd_taken_i && (upd_cur != '0)) upd_new = upd_cur - W_CTR'(1);
  end

  // Counter storage: sweep writes during INIT, resolve writes during RUN.
  always_ff @(posedge clk) begin
    if (init_wr) tbl[ptr] <= INITV;
    else if (upd_fire && reset) tbl[upd_idx_i] <= upd_new;
  end

  // Global history and the registered prediction (with update forwarding).
  always_ff @(posedge clk) begin
    if (!reset) begin
      ghr        <= '0;
      pred_v_o   <= 1'b0;
      pred_o     <= 1'b0;
      pred_idx_o <= '0;
    end else if (run && clr_i) begin
      ghr      <= '0;
      pred_v_o <= 1'b0;
    end else begin
      pred_v_o <= lk_fire;
      if (lk_fire) begin
        pred_idx_o <= lk_idx;
        pred_o     <= fwd_hit ? upd_new[W_CTR-1] : tbl[lk_idx][W_CTR-1];
      end
      if (upd_fire && (USE_GHR != 0)) ghr <= ghr_shift[N_IDX-1:0];
    end
  end

endmodule
